// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: architectural register file geometry and the
// address type used by the register file and its scoreboard.
package RISCV_PKG;

    localparam int REG_WIDTH          = 32;
    localparam int REG_COUNT          = 32;
    localparam int ADDRESS_PORT_WIDTH = $clog2(REG_COUNT);

    typedef logic [ADDRESS_PORT_WIDTH-1:0] reg_addr_t;

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        RD_SRC_ZERO   = 2'd0,
        RD_SRC_STORE  = 2'd1,
        RD_SRC_BYPASS = 2'd2
    } rd_src_e;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback or flush, plus a registered count of pending registers.
module scoreboard_bits
    import RISCV_PKG::*;
#(
    parameter  int NREG      = REG_COUNT,
    parameter  int NUM_WRITE = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          i_issue_en,
    input  logic [AW-1:0]                 i_issue_rd,
    input  logic                          i_flush,
    input  logic [NUM_WRITE-1:0]          i_wr_en,
    input  logic [NUM_WRITE-1:0][AW-1:0]  i_wr_addr,
    output logic [NREG-1:0]               o_pending,
    output logic [AW:0]                   o_pending_count
);

    logic [NREG-1:0] r_pending;
    logic [AW:0]     r_count;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_pending_nxt;
    logic [AW:0]     w_count_nxt;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch for the untouched paths.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_issue_en && (i_issue_rd != '0)) begin
            w_set[i_issue_rd] = 1'b1;
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (i_wr_en[w] && (i_wr_addr[w] != '0)) begin
                w_clr[i_wr_addr[w]] = 1'b1;
            end
        end
        // Issue is applied last so it survives both a same-cycle writeback and a flush.
        w_pending_nxt = (i_flush ? '0 : (r_pending & ~w_clr)) | w_set;
    end

    // NOTE: blocking assignments are correct here: the accumulator is a purely
    // combinational chain evaluated in order, not state.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_count_nxt = w_count_nxt + {{AW{1'b0}}, w_pending_nxt[i]};
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign o_pending       = r_pending;
    assign o_pending_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard
    import RISCV_PKG::*;
#(
    parameter  int NUM_READ  = 2,
    parameter  int NUM_WRITE = 1,
    parameter  int XLEN      = REG_WIDTH,
    parameter  int NREG      = REG_COUNT,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                           CLK,
    input  logic                           Reset,
    input  logic [NUM_READ-1:0][AW-1:0]    RdAddr,
    output logic [NUM_READ-1:0][XLEN-1:0]  RdData,
    output logic [NUM_READ-1:0]            RdReady,
    input  logic [NUM_WRITE-1:0]           WrEn,
    input  logic [NUM_WRITE-1:0][AW-1:0]   WrAddr,
    input  logic [NUM_WRITE-1:0][XLEN-1:0] WrData,
    input  logic                           IssueEn,
    input  logic [AW-1:0]                  IssueRd,
    input  logic                           Flush,
    output logic [AW:0]                    PendingCount
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_pending;
    rd_src_e         w_rd_src [NUM_READ];
`ifdef REGFILE_BYPASS_EN
    logic [NUM_READ-1:0][XLEN-1:0] w_byp_data;
`endif

    scoreboard_bits #(
        .NREG      (NREG),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard_bits (
        .CLK             (CLK),
        .Reset           (Reset),
        .i_issue_en      (IssueEn),
        .i_issue_rd      (IssueRd),
        .i_flush         (Flush),
        .i_wr_en         (WrEn),
        .i_wr_addr       (WrAddr),
        .o_pending       (w_pending),
        .o_pending_count (PendingCount)
    );

    // NOTE: the storage array is reset on purpose so every register reads 0
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // Higher-numbered ports are visited last, so they win on a collision.
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (WrEn[w] && (WrAddr[w] != '0)) begin
                    r_regs[WrAddr[w]] <= WrData[w];
                end
            end
        end
    end

    // Source selection per read port; x0 and reset both force the zero source.
    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            w_rd_src[r] = RD_SRC_ZERO;
`ifdef REGFILE_BYPASS_EN
            w_byp_data[r] = '0;
`endif
            if (!Reset && (RdAddr[r] != '0)) begin
                w_rd_src[r] = RD_SRC_STORE;
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (WrEn[w] && (WrAddr[w] == RdAddr[r])) begin
                        w_rd_src[r]   = RD_SRC_BYPASS;
                        w_byp_data[r] = WrData[w];
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            RdData[r]  = '0;
            RdReady[r] = 1'b1;
            case (w_rd_src[r])
                RD_SRC_STORE: begin
                    RdData[r]  = r_regs[RdAddr[r]];
                    RdReady[r] = ~w_pending[RdAddr[r]];
                end
`ifdef REGFILE_BYPASS_EN
                RD_SRC_BYPASS: begin
                    RdData[r]  = w_byp_data[r];
                    RdReady[r] = 1'b1;
                end
`endif
                default: begin
                    RdData[r]  = '0;
                    RdReady[r] = 1'b1;
                end
            endcase
        end
    end

endmodule
